lifegame_engine: RTL

- Parametrised Game-of-Life generation engine that replaces the fixed-size cell update inside the lifegame top.
- Holds a GRID_W x GRID_H cell array and computes one full generation per step request, one row per clock.
- Boundary mode is selectable: toroidal wrap or dead border.
- Provides a row load port for seeding, a registered row read port for the VGA renderer, a generation counter and a stable flag.

---
 rtl/lifegame_pkg.sv | 16 +
 rtl/lifegame_row_update.sv | 51 +++++
 rtl/lifegame_engine.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lifegame_pkg.sv
// Shared types and the Game-of-Life cell rule for the generation engine.
package lifegame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int NCOUNT_W = 4;

    function automatic logic next_cell(input logic cur, input logic [NCOUNT_W-1:0] n);
        return (n == NCOUNT_W'(3)) || (cur && (n == NCOUNT_W'(2)));
    endfunction

endpackage

// File: rtl/lifegame_row_update.sv
// Combinational next-generation computation for one row, given the rows above and below.
module lifegame_row_update
    import lifegame_pkg::*;
#(
    parameter int GRID_W = 64,
    parameter int WRAP   = 1
) (
    input  logic [GRID_W-1:0] above,
    input  logic [GRID_W-1:0] cur,
    input  logic [GRID_W-1:0] below,
    output logic [GRID_W-1:0] next_row
);

    logic [GRID_W+1:0] above_ext;
    logic [GRID_W+1:0] cur_ext;
    logic [GRID_W+1:0] below_ext;

    // Bit 0 is the left neighbour of column 0, bit GRID_W+1 the right neighbour of column GRID_W-1.
    function automatic logic [GRID_W+1:0] pad(input logic [GRID_W-1:0] row);
        logic edge_l;
        logic edge_r;
        edge_l = (WRAP != 0) ? row[GRID_W-1] : 1'b0;
        edge_r = (WRAP != 0) ? row[0] : 1'b0;
        return {edge_r, row, edge_l};
    endfunction

    function automatic logic [NCOUNT_W-1:0] ncount(
        input logic [2:0] a3,
        input logic [2:0] b3,
        input logic       left,
        input logic       right
    );
        return NCOUNT_W'(a3[0]) + NCOUNT_W'(a3[1]) + NCOUNT_W'(a3[2]) +
               NCOUNT_W'(b3[0]) + NCOUNT_W'(b3[1]) + NCOUNT_W'(b3[2]) +
               NCOUNT_W'(left)  + NCOUNT_W'(right);
    endfunction

    assign above_ext = pad(above);
    assign cur_ext   = pad(cur);
    assign below_ext = pad(below);

    always_comb begin
        next_row = '0;
        for (int c = 0; c < GRID_W; c++) begin
            next_row[c] = next_cell(cur[c],
                                    ncount(above_ext[c +: 3], below_ext[c +: 3],
                                           cur_ext[c], cur_ext[c+2]));
        end
    end

endmodule

// File: rtl/lifegame_engine.sv
// Game-of-Life generation engine: one row per clock, selectable torus or dead border.
//
// state | meaning
// IDLE  | waiting; loads and step requests accepted
// CALC  | updating row row_idx in place, one row per cycle
// FIN   | done pulse; generation counter and stable flag updated
module lifegame_engine
    import lifegame_pkg::*;
#(
    parameter int GRID_W = 64,
    parameter int GRID_H = 48,
    parameter int WRAP   = 1,
    parameter int GEN_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       step,
    output logic                       busy,
    output logic                       done,
    input  logic                       load_en,
    input  logic [$clog2(GRID_H)-1:0]  load_row,
    input  logic [GRID_W-1:0]          load_data,
    input  logic [$clog2(GRID_H)-1:0]  rd_row,
    output logic [GRID_W-1:0]          rd_data,
    output logic [GEN_W-1:0]           gen_count,
    output logic                       stable
);

    localparam int ROW_W = $clog2(GRID_H);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_H - 1);
    localparam logic [ROW_W:0]   ROW_LIMIT = (ROW_W + 1)'(GRID_H);

    state_t state, state_next;

    logic [GRID_W-1:0] grid [GRID_H];
    logic [ROW_W-1:0]  row_idx;
    logic [ROW_W-1:0]  row_idx_next;
    logic [GRID_W-1:0] prev_row;
    logic [GRID_W-1:0] row0_orig;
    logic [GRID_W-1:0] above;
    logic [GRID_W-1:0] cur;
    logic [GRID_W-1:0] below;
    logic [GRID_W-1:0] next_row;
    logic              change;
    logic              start;
    logic              last_row;
    logic              load_ok;
    logic              rd_ok;

    assign start    = (state == IDLE) && step && !load_en;
    assign last_row = (row_idx == LAST_ROW);
    assign load_ok  = (state == IDLE) && load_en && ({1'b0, load_row} < ROW_LIMIT);
    assign rd_ok    = ({1'b0, rd_row} < ROW_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_row) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Rows are rewritten in place, so the original of the previous row and of row 0
    // are kept aside for the neighbours of the following row and of the wrapped last row.
    always_comb begin
        cur          = grid[row_idx];
        row_idx_next = last_row ? '0 : row_idx + ROW_W'(1);
        if (row_idx == '0) begin
            above = (WRAP != 0) ? grid[GRID_H-1] : '0;
        end else begin
            above = prev_row;
        end
        if (last_row) begin
            below = (WRAP != 0) ? row0_orig : '0;
        end else begin
            below = grid[row_idx_next];
        end
    end

    lifegame_row_update #(
        .GRID_W (GRID_W),
        .WRAP   (WRAP)
    ) u_row_update (
        .above    (above),
        .cur      (cur),
        .below    (below),
        .next_row (next_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < GRID_H; i++) begin
                grid[i] <= '0;
            end
            row_idx   <= '0;
            prev_row  <= '0;
            row0_orig <= '0;
            change    <= 1'b0;
            gen_count <= '0;
            stable    <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_data <= rd_ok ? grid[rd_row] : '0;
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        grid[load_row] <= load_data;
                    end else if (start) begin
                        row_idx <= '0;
                        change  <= 1'b0;
                    end
                end
                CALC: begin
                    grid[row_idx] <= next_row;
                    prev_row      <= cur;
                    if (row_idx == '0) begin
                        row0_orig <= cur;
                    end
                    if (next_row != cur) begin
                        change <= 1'b1;
                    end
                    row_idx <= row_idx_next;
                end
                FIN: begin
                    gen_count <= gen_count + GEN_W'(1);
                    stable    <= !change;
                end
                default: ;
            endcase
        end
    end

endmodule
